// File: rtl/tl45_memory_ls.sv
// tl45 memory stage: issues one pipelined-Wishbone transfer per load/store/IO op,
// applies byte lanes and extension, and reports alignment, bus-error and timeout faults.
module tl45_memory_ls #(
  parameter int unsigned     AW      = 30,
  parameter logic [AW-15:0]  IO_HI   = 16'h00FF,
  parameter int unsigned     TIMEOUT = 255,
  parameter logic [31:0]     ERR_VAL = 32'h13371337
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_pipe_stall,
  output logic          o_pipe_stall,

  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data,

  input  logic [4:0]    i_buf_opcode,
  input  logic [3:0]    i_buf_dr,
  input  logic [31:0]   i_buf_sr1_val,
  input  logic [31:0]   i_buf_sr2_val,
  input  logic [31:0]   i_buf_imm,

  output logic [3:0]    o_buf_dr,
  output logic [31:0]   o_buf_val,
  output logic          o_fault,
  output logic [1:0]    o_fault_cause
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [4:0] {
    OP_IN  = 5'h10,
    OP_OUT = 5'h11,
    OP_LW  = 5'h14,
    OP_SW  = 5'h15,
    OP_LB  = 5'h16,
    OP_LBU = 5'h17,
    OP_LH  = 5'h18,
    OP_LHU = 5'h19,
    OP_SB  = 5'h1A,
    OP_SH  = 5'h1B
  } opcode_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    HOLD,
    OUT
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ALIGN   = 2'b01,
    CAUSE_BUS     = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_e;

  typedef struct packed {
    logic  valid;
    logic  io;
    logic  write;
    logic  sign;
    size_e size;
  } dec_t;

  state_e        state, state_next;
  dec_t          dec;

  logic [31:0]   ea;
  logic [1:0]    lane;
  logic [31:0]   store_src;
  logic          misaligned;
  logic          launch;
  logic          go_strobe;
  logic [AW-1:0] launch_addr;
  logic [3:0]    launch_sel;
  logic [31:0]   launch_data;

  logic [3:0]    req_dr;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_sel;
  logic [31:0]   req_data;
  logic          req_we;
  size_e         req_size;
  logic          req_sign;
  logic [1:0]    req_lane;

  logic [3:0]    res_dr;
  logic [31:0]   res_val;
  cause_e        res_cause;

  logic [15:0]   wait_cnt, wait_cnt_next;
  logic          finish;
  cause_e        fin_cause;
  logic [3:0]    out_dr;
  logic [31:0]   out_val;
  cause_e        out_cause;

  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec = '0;
    case (i_buf_opcode)
      OP_IN:  begin dec.valid = 1'b1; dec.io = 1'b1; dec.size = SZ_WORD; end
      OP_OUT: begin dec.valid = 1'b1; dec.io = 1'b1; dec.write = 1'b1; dec.size = SZ_WORD; end
      OP_LW:  begin dec.valid = 1'b1; dec.size = SZ_WORD; end
      OP_SW:  begin dec.valid = 1'b1; dec.write = 1'b1; dec.size = SZ_WORD; end
      OP_LB:  begin dec.valid = 1'b1; dec.sign = 1'b1; dec.size = SZ_BYTE; end
      OP_LBU: begin dec.valid = 1'b1; dec.size = SZ_BYTE; end
      OP_LH:  begin dec.valid = 1'b1; dec.sign = 1'b1; dec.size = SZ_HALF; end
      OP_LHU: begin dec.valid = 1'b1; dec.size = SZ_HALF; end
      OP_SB:  begin dec.valid = 1'b1; dec.write = 1'b1; dec.size = SZ_BYTE; end
      OP_SH:  begin dec.valid = 1'b1; dec.write = 1'b1; dec.size = SZ_HALF; end
      default: ;
    endcase
  end

  assign ea          = i_buf_sr1_val + i_buf_imm;
  assign lane        = dec.io ? 2'b00 : ea[1:0];
  assign launch_addr = dec.io ? {IO_HI, i_buf_imm[13:0]} : ea[AW+1:2];
  assign store_src   = dec.io ? i_buf_sr1_val : i_buf_sr2_val;
  assign misaligned  = !dec.io && (((dec.size == SZ_HALF) && lane[0]) ||
                                   ((dec.size == SZ_WORD) && (lane != 2'b00)));
  assign launch      = (state == IDLE) && dec.valid && !i_pipe_stall;
  assign go_strobe   = launch && !misaligned;

  always_comb begin
    launch_sel  = 4'b1111;
    launch_data = '0;
    case (dec.size)
      SZ_BYTE: launch_sel = 4'b0001 << lane;
      SZ_HALF: launch_sel = lane[1] ? 4'b1100 : 4'b0011;
      default: launch_sel = 4'b1111;
    endcase
    if (dec.write) begin
      case (dec.size)
        SZ_BYTE: launch_data = {4{store_src[7:0]}};
        SZ_HALF: launch_data = {2{store_src[15:0]}};
        default: launch_data = store_src;
      endcase
    end
  end

  // Read data is steered with the lane captured at launch, never the live operands.
  always_comb begin
    ld_byte = i_wb_data[7:0];
    case (req_lane)
      2'd1:    ld_byte = i_wb_data[15:8];
      2'd2:    ld_byte = i_wb_data[23:16];
      2'd3:    ld_byte = i_wb_data[31:24];
      default: ld_byte = i_wb_data[7:0];
    endcase
    ld_half = req_lane[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    case (req_size)
      SZ_BYTE: load_val = {{24{req_sign & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = {{16{req_sign & ld_half[15]}}, ld_half};
      default: load_val = i_wb_data;
    endcase
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    finish        = 1'b0;
    fin_cause     = CAUSE_NONE;
    out_dr        = '0;
    out_val       = '0;
    out_cause     = CAUSE_NONE;

    case (state)
      IDLE: begin
        if (launch) begin
          state_next = misaligned ? OUT : STROBE;
          if (misaligned) out_cause = CAUSE_ALIGN;
        end
      end
      STROBE: begin
        if (!i_wb_stall) begin
          wait_cnt_next = '0;
          if (i_wb_ack || i_wb_err) begin
            finish    = 1'b1;
            fin_cause = i_wb_err ? CAUSE_BUS : CAUSE_NONE;
          end else begin
            state_next = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (i_wb_ack || i_wb_err) begin
          finish    = 1'b1;
          fin_cause = i_wb_err ? CAUSE_BUS : CAUSE_NONE;
        end else if (TIMEOUT_EN && (wait_cnt + 16'd1 == TIMEOUT_CNT)) begin
          finish    = 1'b1;
          fin_cause = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      HOLD: begin
        if (!i_pipe_stall) begin
          state_next = OUT;
          out_dr     = res_dr;
          out_val    = res_val;
          out_cause  = res_cause;
        end
      end
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Stores report no writeback even when the bus faults; loads substitute ERR_VAL.
    if (finish) begin
      state_next = i_pipe_stall ? HOLD : OUT;
      out_dr     = req_we ? 4'd0 : req_dr;
      out_val    = req_we ? 32'd0 : ((fin_cause == CAUSE_NONE) ? load_val : ERR_VAL);
      out_cause  = fin_cause;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      o_buf_dr      <= '0;
      o_buf_val     <= '0;
      o_fault       <= 1'b0;
      o_fault_cause <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state_next == OUT) begin
        o_buf_dr      <= out_dr;
        o_buf_val     <= out_val;
        o_fault       <= (out_cause != CAUSE_NONE);
        o_fault_cause <= out_cause;
      end else begin
        o_buf_dr      <= '0;
        o_buf_val     <= '0;
        o_fault       <= 1'b0;
        o_fault_cause <= '0;
      end
    end
  end

  // NOTE: request and result holding registers are left unreset; the state register gates every use of them.
  always_ff @(posedge i_clk) begin
    if (go_strobe) begin
      req_dr   <= i_buf_dr;
      req_addr <= launch_addr;
      req_sel  <= launch_sel;
      req_data <= launch_data;
      req_we   <= dec.write;
      req_size <= dec.size;
      req_sign <= dec.sign;
      req_lane <= lane;
    end
    if (finish) begin
      res_dr    <= out_dr;
      res_val   <= out_val;
      res_cause <= out_cause;
    end
  end

  assign o_wb_cyc  = (state == STROBE) || (state == WAIT_ACK);
  assign o_wb_stb  = (state == STROBE);
  assign o_wb_we   = o_wb_stb && req_we;
  assign o_wb_addr = o_wb_stb ? req_addr : '0;
  assign o_wb_data = o_wb_stb ? req_data : '0;
  assign o_wb_sel  = o_wb_stb ? req_sel  : '0;

  assign o_pipe_stall = i_pipe_stall || (state == STROBE) || (state == WAIT_ACK) ||
                        (state == HOLD) || ((state == IDLE) && dec.valid);

endmodule

// File: tb/tb_tl45_memory_ls.sv
// Self-checking bench for tl45_memory_ls: directed cases plus randomized transactions
// compared cycle by cycle against a behavioural model of the memory stage.
module tb_tl45_memory_ls;

  localparam int          TO      = 4;
  localparam logic [15:0] IO_HI   = 16'h00FF;
  localparam logic [31:0] ERR_VAL = 32'h13371337;

  localparam logic [4:0] OP_IN = 5'h10, OP_OUT = 5'h11, OP_LW = 5'h14, OP_SW = 5'h15,
                         OP_LB = 5'h16, OP_LBU = 5'h17, OP_LH = 5'h18, OP_LHU = 5'h19,
                         OP_SB = 5'h1A, OP_SH = 5'h1B;

  localparam int RESP_ACK = 0, RESP_ERR = 1, RESP_NONE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_stall_in;
  logic        pipe_stall_out;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_rdata;
  logic [4:0]  opcode;
  logic [3:0]  buf_dr;
  logic [31:0] sr1, sr2, imm;
  logic [3:0]  out_dr;
  logic [31:0] out_val;
  logic        fault;
  logic [1:0]  fault_cause;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tl45_memory_ls #(.AW(30), .IO_HI(IO_HI), .TIMEOUT(TO), .ERR_VAL(ERR_VAL)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_pipe_stall  (pipe_stall_in),
    .o_pipe_stall  (pipe_stall_out),
    .o_wb_cyc      (wb_cyc),
    .o_wb_stb      (wb_stb),
    .o_wb_we       (wb_we),
    .o_wb_addr     (wb_addr),
    .o_wb_data     (wb_wdata),
    .o_wb_sel      (wb_sel),
    .i_wb_ack      (wb_ack),
    .i_wb_stall    (wb_stall),
    .i_wb_err      (wb_err),
    .i_wb_data     (wb_rdata),
    .i_buf_opcode  (opcode),
    .i_buf_dr      (buf_dr),
    .i_buf_sr1_val (sr1),
    .i_buf_sr2_val (sr2),
    .i_buf_imm     (imm),
    .o_buf_dr      (out_dr),
    .o_buf_val     (out_val),
    .o_fault       (fault),
    .o_fault_cause (fault_cause)
  );

  typedef struct packed {
    logic        mis;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] lval;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the op's access size and byte offset, using plain arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] rdata);
    exp_t        e;
    int          nb;
    int          off;
    logic        io;
    logic        sgn;
    logic [31:0] ea, mask, wsrc;
    ea  = a + im;
    io  = (op == OP_IN) || (op == OP_OUT);
    case (op)
      OP_LB, OP_LBU, OP_SB: nb = 1;
      OP_LH, OP_LHU, OP_SH: nb = 2;
      default:              nb = 4;
    endcase
    sgn    = (op == OP_LB) || (op == OP_LH);
    e.we   = (op == OP_OUT) || (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    off    = io ? 0 : int'(ea % 32'd4);
    e.mis  = (off % nb) != 0;
    e.addr = io ? 30'((32'(IO_HI) << 14) | (im % 32'd16384)) : 30'(ea / 32'd4);
    e.sel  = 4'(((1 << nb) - 1) << off);
    wsrc   = (op == OP_OUT) ? a : b;
    mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (nb == 4)      e.wdata = wsrc;
    else if (nb == 2) e.wdata = (wsrc & mask) * 32'h0001_0001;
    else              e.wdata = (wsrc & mask) * 32'h0101_0101;
    e.lval = (rdata >> (8 * off)) & mask;
    if (sgn && e.lval[8 * nb - 1]) e.lval = e.lval | ~mask;
    return e;
  endfunction

  // One transaction on a fixed schedule: nstall stalled strobe cycles, response after w
  // WAIT_ACK cycles (or none), then i_pipe_stall held so the result waits h cycles.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [3:0] dr,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input int nstall, input int resp, input int w, input int h,
                        input logic [31:0] rdata);
    exp_t        e;
    int          s, r, hh, t;
    logic [3:0]  xdr;
    logic [31:0] xval;
    logic [1:0]  xcause;
    e  = model(op, a, b, im, rdata);
    s  = e.mis ? 0 : nstall + 1;
    r  = e.mis ? 0 : ((resp == RESP_NONE) ? s + TO : s + w);
    hh = e.mis ? 0 : h;
    t  = r + hh + 1;
    if (e.mis) begin
      xdr = 4'd0; xval = 32'd0; xcause = 2'b01;
    end else begin
      xdr    = e.we ? 4'd0 : dr;
      xval   = e.we ? 32'd0 : ((resp == RESP_ACK) ? e.lval : ERR_VAL);
      xcause = (resp == RESP_ERR) ? 2'b10 : ((resp == RESP_NONE) ? 2'b11 : 2'b00);
    end

    @(negedge clk);
    opcode = op; buf_dr = dr; sr1 = a; sr2 = b; imm = im;
    pipe_stall_in = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    #1 check({tag, " launch_stall"}, 64'(pipe_stall_out), 64'd1);

    for (int i = 1; i <= t + 1; i++) begin
      @(negedge clk);
      if (i == 1) begin
        opcode = 5'h00; buf_dr = 4'($urandom); sr1 = $urandom; sr2 = $urandom; imm = $urandom;
      end
      wb_stall      = (i <= nstall);
      wb_ack        = !e.mis && (resp == RESP_ACK) && (i == r);
      wb_err        = !e.mis && (resp == RESP_ERR) && (i == r);
      wb_rdata      = (i == r) ? rdata : $urandom;
      pipe_stall_in = (i >= r) && (i < r + hh);
      #1;
      check($sformatf("%s c%0d cyc/stb/we/stall", tag, i),
            64'({wb_cyc, wb_stb, wb_we, pipe_stall_out}),
            64'({!e.mis && (i <= r), !e.mis && (i <= s), !e.mis && e.we && (i <= s), i < t}));
      if (i == 1 && !e.mis) begin
        check({tag, " addr/sel"}, 64'({wb_addr, wb_sel}), 64'({e.addr, e.sel}));
        if (e.we) check({tag, " wdata"}, 64'(wb_wdata), 64'(e.wdata));
      end
      if (i == t)
        check({tag, " bus idle at result"}, 64'({wb_addr, wb_sel, wb_wdata}), 64'd0);
      check($sformatf("%s c%0d result", tag, i),
            64'({out_dr, out_val, fault, fault_cause}),
            (i == t) ? 64'({xdr, xval, xcause != 2'b00, xcause}) : 64'd0);
    end
  endtask

  logic [4:0] mem_ops [10] = '{OP_IN, OP_OUT, OP_LW, OP_SW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH};

  initial begin
    int rr, resp;
    reset = 1'b1; pipe_stall_in = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    wb_rdata = '0; opcode = '0; buf_dr = '0; sr1 = '0; sr2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs",
          64'({wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, out_dr, fault, fault_cause, pipe_stall_out}), 64'd0);
    check("reset val/wdata", {out_val, wb_wdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("lw_fast", OP_LW, 4'd3, 32'h100, 32'h0, 32'd4, 0, RESP_ACK, 0, 0, 32'hDEADBEEF);
    run_op("lb_sign", OP_LB, 4'd5, 32'h100, 32'h0, 32'd3, 0, RESP_ACK, 0, 0, 32'h8011_2233);
    run_op("lbu_zero", OP_LBU, 4'd6, 32'h100, 32'h0, 32'd3, 0, RESP_ACK, 1, 0, 32'h8011_2233);
    run_op("sh_hi", OP_SH, 4'd1, 32'h100, 32'h1234, 32'd2, 0, RESP_ACK, 0, 0, 32'h0);
    run_op("lh_misalign", OP_LH, 4'd2, 32'h100, 32'h0, 32'd1, 0, RESP_ACK, 0, 0, 32'h0);
    run_op("lw_misalign", OP_LW, 4'd2, 32'h100, 32'h0, 32'd2, 0, RESP_ACK, 0, 0, 32'h0);
    run_op("lw_stall_hold", OP_LW, 4'd8, 32'h200, 32'h0, 32'd8, 3, RESP_ACK, 0, 2, 32'hCAFE_F00D);
    run_op("lw_timeout", OP_LW, 4'd7, 32'h300, 32'h0, 32'd0, 0, RESP_NONE, 0, 0, 32'h0);
    run_op("sw_err", OP_SW, 4'd9, 32'h400, 32'h5555_AAAA, 32'd0, 1, RESP_ERR, 1, 0, 32'h0);
    run_op("lhu_hi", OP_LHU, 4'd10, 32'h100, 32'h0, 32'd2, 0, RESP_ACK, 0, 0, 32'hBEEF_1234);
    run_op("lh_lo_sign", OP_LH, 4'd11, 32'h100, 32'h0, 32'd0, 0, RESP_ACK, 2, 1, 32'hBEEF_8001);
    run_op("sb_lane1", OP_SB, 4'd4, 32'h0FF, 32'h0000_00AB, 32'd2, 1, RESP_ACK, 0, 0, 32'h0);
    run_op("in_io", OP_IN, 4'd12, 32'hFFFF_FFFF, 32'h0, 32'h0000_4123, 0, RESP_ACK, 0, 0, 32'h0BAD_CAFE);
    run_op("out_io", OP_OUT, 4'd13, 32'h7654_3210, 32'h1111_1111, 32'h0000_0077, 0, RESP_ACK, 1, 0, 32'h0);
    run_op("lw_err", OP_LW, 4'd14, 32'h500, 32'h0, 32'd4, 0, RESP_ERR, 0, 1, 32'h0);

    // A non-memory opcode must neither stall nor start a bus cycle.
    @(negedge clk);
    opcode = 5'h05; buf_dr = 4'd9;
    #1 check("nonmem stall", 64'(pipe_stall_out), 64'd0);
    @(negedge clk);
    #1 check("nonmem idle", 64'({wb_cyc, out_dr, fault}), 64'd0);
    opcode = 5'h00;

    // Downstream stall keeps a pending op in IDLE.
    @(negedge clk);
    opcode = OP_LW; sr1 = 32'h600; imm = 32'd0; buf_dr = 4'd3; pipe_stall_in = 1'b1;
    #1 check("prelaunch stall", 64'(pipe_stall_out), 64'd1);
    @(negedge clk);
    #1 check("prelaunch no cyc", 64'(wb_cyc), 64'd0);
    run_op("lw_after_stall", OP_LW, 4'd3, 32'h600, 32'h0, 32'd0, 0, RESP_ACK, 0, 0, 32'h1234_5678);

    for (int n = 0; n < 40; n++) begin
      rr   = int'($urandom_range(0, 9));
      resp = (rr < 7) ? RESP_ACK : ((rr < 9) ? RESP_ERR : RESP_NONE);
      run_op($sformatf("rnd%0d", n), mem_ops[$urandom_range(0, 9)], 4'($urandom_range(1, 15)),
             $urandom, $urandom, 32'($urandom_range(0, 63)), int'($urandom_range(0, 2)), resp,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
    end

    // Reset while waiting for an ack drops the cycle and discards the late response.
    @(negedge clk);
    opcode = OP_LW; sr1 = 32'h700; imm = 32'd0; buf_dr = 4'd5; pipe_stall_in = 1'b0; wb_stall = 1'b0;
    @(negedge clk);
    opcode = 5'h00;
    @(negedge clk);
    #1 check("rst wait_ack", 64'({wb_cyc, wb_stb}), 64'b10);
    @(negedge clk);
    reset = 1'b1; pipe_stall_in = 1'b1;
    @(negedge clk);
    #1 check("rst cyc/stb drop", 64'({wb_cyc, wb_stb}), 64'd0);
    check("rst stall follows in=1", 64'(pipe_stall_out), 64'd1);
    pipe_stall_in = 1'b0;
    #1 check("rst stall follows in=0", 64'(pipe_stall_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    wb_ack = 1'b1; wb_rdata = 32'hFEED_FACE;
    @(negedge clk);
    wb_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("rst late ack ignored %0d", i),
               64'({wb_cyc, out_dr, out_val, fault, fault_cause}), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
